rx_iq_buffer: RTL and testbench

Ping-pong sample buffer downstream of the receiver channel's CIC decimation chain. Each output strobe from the channel presents one complex sample. The buffer captures it and stores it as three 16-bit words: I low, Q low, and packed top bytes. When a half of NSAMPS samples fills, it flags that half to the CPU-side reader, and the other half keeps filling. Everything runs on `adc_clk`; CDC to the CPU domain is handled outside this block.

---
 rtl/rx_iq_buffer.sv | 190 +++++++++++++++++++
 tb/tb_rx_iq_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_buffer.sv
// Ping-pong I/Q sample buffer: each accepted complex sample is stored as three
// 16-bit words; completed halves are flagged to the CPU-side reader.
// IN_WIDTH must lie in 16..24; NSAMPS must be a power of two and at least 2.
module rx_iq_buffer #(
  parameter int IN_WIDTH = 24,
  parameter int NSAMPS   = 256
) (
  input  logic                      adc_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      in_strobe,
  input  logic [IN_WIDTH-1:0]       in_i,
  input  logic [IN_WIDTH-1:0]       in_q,
  input  logic                      rd_start,
  input  logic                      rd_next,
  output logic [15:0]               rd_data,
  output logic                      buf_ready,
  output logic                      buf_sel,
  output logic                      ovf_buf,
  output logic                      ovf_strobe,
  output logic [$clog2(NSAMPS):0]   wr_count
);

  localparam int HALF_WORDS = 3 * NSAMPS;
  localparam int DEPTH      = 2 * HALF_WORDS;
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(NSAMPS) + 1;

  localparam logic [AW-1:0] HALF_BASE   = AW'(HALF_WORDS);
  localparam logic [AW-1:0] HALF_LAST   = AW'(HALF_WORDS - 1);
  localparam logic [AW-1:0] TOP_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(NSAMPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_I,
    WR_Q,
    WR_X
  } wr_state_e;

  wr_state_e           state_q, state_d;
  logic [IN_WIDTH-1:0] hold_i_q, hold_i_d;
  logic [IN_WIDTH-1:0] hold_q_q, hold_q_d;
  logic                wr_half_q, wr_half_d;
  logic [CW-1:0]       wr_count_q, wr_count_d;
  logic                buf_ready_q, buf_ready_d;
  logic                buf_sel_q, buf_sel_d;
  logic                ovf_buf_q, ovf_buf_d;
  logic                ovf_strobe_q, ovf_strobe_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]         rd_data_q;

  logic                half_done;
  logic                wr_en;
  logic [1:0]          wr_k;
  logic [AW-1:0]       wr_addr;
  logic [15:0]         wr_data;
  logic                rd_en;

  logic [15:0]         mem [DEPTH];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    hold_i_d     = hold_i_q;
    hold_q_d     = hold_q_q;
    wr_half_d    = wr_half_q;
    wr_count_d   = wr_count_q;
    buf_sel_d    = buf_sel_q;
    ovf_buf_d    = ovf_buf_q;
    ovf_strobe_d = ovf_strobe_q;
    half_done    = 1'b0;
    wr_en        = 1'b0;
    wr_k         = 2'd0;

    if (!enable) begin
      state_d      = IDLE;
      wr_half_d    = 1'b0;
      wr_count_d   = '0;
      ovf_buf_d    = 1'b0;
      ovf_strobe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_strobe) begin
            hold_i_d = in_i;
            hold_q_d = in_q;
            state_d  = WR_I;
          end
        end
        WR_I: begin
          wr_en   = 1'b1;
          wr_k    = 2'd0;
          state_d = WR_Q;
        end
        WR_Q: begin
          wr_en   = 1'b1;
          wr_k    = 2'd1;
          state_d = WR_X;
        end
        WR_X: begin
          wr_en   = 1'b1;
          wr_k    = 2'd2;
          state_d = IDLE;
          if (wr_count_q == LAST_SAMPLE) begin
            half_done  = 1'b1;
            wr_count_d = '0;
            wr_half_d  = ~wr_half_q;
            buf_sel_d  = wr_half_q;
            if (buf_ready_q) ovf_buf_d = 1'b1;
          end else begin
            wr_count_d = wr_count_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && in_strobe) ovf_strobe_d = 1'b1;
    end

    // A completion in the same cycle as rd_start leaves the flag set.
    buf_ready_d = half_done | (buf_ready_q & ~rd_start);
  end

  always_comb begin
    wr_addr = (wr_half_q ? HALF_BASE : '0)
            + AW'({wr_count_q, 1'b0}) + AW'(wr_count_q) + AW'(wr_k);
    case (wr_k)
      2'd0:    wr_data = hold_i_q[15:0];
      2'd1:    wr_data = hold_q_q[15:0];
      default: wr_data = {hold_i_q[IN_WIDTH-1 -: 8], hold_q_q[IN_WIDTH-1 -: 8]};
    endcase
  end

  always_comb begin
    rd_en    = rd_start | rd_next;
    rd_ptr_d = rd_ptr_q;
    if (rd_start) begin
      rd_ptr_d = buf_sel_q ? HALF_BASE : '0;
    end else if (rd_next) begin
      if (rd_ptr_q == HALF_LAST)     rd_ptr_d = '0;
      else if (rd_ptr_q == TOP_LAST) rd_ptr_d = HALF_BASE;
      else                           rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_i_q     <= '0;
      hold_q_q     <= '0;
      wr_half_q    <= 1'b0;
      wr_count_q   <= '0;
      buf_ready_q  <= 1'b0;
      buf_sel_q    <= 1'b0;
      ovf_buf_q    <= 1'b0;
      ovf_strobe_q <= 1'b0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_i_q     <= hold_i_d;
      hold_q_q     <= hold_q_d;
      wr_half_q    <= wr_half_d;
      wr_count_q   <= wr_count_d;
      buf_ready_q  <= buf_ready_d;
      buf_sel_q    <= buf_sel_d;
      ovf_buf_q    <= ovf_buf_d;
      ovf_strobe_q <= ovf_strobe_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the RAM array has no reset; only the read register is cleared.
  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n)   rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_ptr_d];
  end

  assign rd_data    = rd_data_q;
  assign buf_ready  = buf_ready_q;
  assign buf_sel    = buf_sel_q;
  assign ovf_buf    = ovf_buf_q;
  assign ovf_strobe = ovf_strobe_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Bench for rx_iq_buffer (NSAMPS=4, IN_WIDTH=24): read words are checked by a
// scoreboard monitor; status flags are checked against hand-derived constants.
module tb_rx_iq_buffer;

  localparam int IN_WIDTH = 24;
  localparam int NSAMPS   = 4;
  localparam int HALF     = 3 * NSAMPS;

  logic                adc_clk   = 1'b0;
  logic                reset_n   = 1'b0;
  logic                enable    = 1'b0;
  logic                in_strobe = 1'b0;
  logic [IN_WIDTH-1:0] in_i      = '0;
  logic [IN_WIDTH-1:0] in_q      = '0;
  logic                rd_start  = 1'b0;
  logic                rd_next   = 1'b0;
  logic [15:0]         rd_data;
  logic                buf_ready;
  logic                buf_sel;
  logic                ovf_buf;
  logic                ovf_strobe;
  logic [2:0]          wr_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_mem [2*HALF];
  int          m_half = 0;
  int          m_count = 0;
  int          m_rptr = 0;
  logic        rd_seen = 1'b0;

  logic [15:0] tbl1 [12] = '{16'h3456, 16'hCDEF, 16'h12AB,
                             16'h3457, 16'hCDEE, 16'h12AB,
                             16'h3458, 16'hCDED, 16'h12AB,
                             16'h3459, 16'hCDEC, 16'h12AB};

  rx_iq_buffer #(.IN_WIDTH(IN_WIDTH), .NSAMPS(NSAMPS)) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .in_strobe  (in_strobe),
    .in_i       (in_i),
    .in_q       (in_q),
    .rd_start   (rd_start),
    .rd_next    (rd_next),
    .rd_data    (rd_data),
    .buf_ready  (buf_ready),
    .buf_sel    (buf_sel),
    .ovf_buf    (ovf_buf),
    .ovf_strobe (ovf_strobe),
    .wr_count   (wr_count)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic model_write(input logic [23:0] i, input logic [23:0] q);
    int base;
    base = m_half * HALF + m_count * 3;
    m_mem[base]     = i[15:0];
    m_mem[base + 1] = q[15:0];
    m_mem[base + 2] = {i[23:16], q[23:16]};
    m_count++;
    if (m_count == NSAMPS) begin
      m_count = 0;
      m_half  = 1 - m_half;
    end
  endtask

  // One sample at 4-cycle spacing; optionally pulses rd_start on the completion edge.
  task automatic send(input logic [23:0] i, input logic [23:0] q,
                      input bit rd_at_end = 1'b0, input int rd_base = 0);
    in_i = i;
    in_q = q;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick();
    tick();
    if (rd_at_end) begin
      rd_start = 1'b1;
      m_rptr = rd_base;
      exp_q.push_back(m_mem[m_rptr]);
    end
    tick();
    rd_start = 1'b0;
    model_write(i, q);
  endtask

  task automatic rd_begin(input int base, input bit use_exp = 1'b0, input logic [15:0] exp = '0);
    rd_start = 1'b1;
    m_rptr = base;
    exp_q.push_back(use_exp ? exp : m_mem[m_rptr]);
    tick();
    rd_start = 1'b0;
    tick();
  endtask

  task automatic rd_step(input bit use_exp = 1'b0, input logic [15:0] exp = '0);
    rd_next = 1'b1;
    if (m_rptr % HALF == HALF - 1) m_rptr = m_rptr - (HALF - 1);
    else                           m_rptr = m_rptr + 1;
    exp_q.push_back(use_exp ? exp : m_mem[m_rptr]);
    tick();
    rd_next = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every read pulse taken at a posedge yields one word.
  always @(posedge adc_clk) rd_seen <= rd_start | rd_next;

  always @(negedge adc_clk) begin
    if (rd_seen && reset_n) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected word queued", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_buf_ready", 32'(buf_ready), 32'h0);
    check("rst_buf_sel", 32'(buf_sel), 32'h0);
    check("rst_ovf_buf", 32'(ovf_buf), 32'h0);
    check("rst_ovf_strobe", 32'(ovf_strobe), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();
    tick();

    // First half: four samples, then read 13 words with wrap
    for (int n = 0; n < 4; n++) begin
      send(24'h123456 + 24'(n), 24'hABCDEF - 24'(n));
      if (n == 1) check("cnt_after_2", 32'(wr_count), 32'd2);
      if (n == 2) check("ready_before_full", 32'(buf_ready), 32'h0);
    end
    check("h0_ready", 32'(buf_ready), 32'h1);
    check("h0_sel", 32'(buf_sel), 32'h0);
    check("h0_cnt", 32'(wr_count), 32'h0);
    check("h0_ovf_buf", 32'(ovf_buf), 32'h0);
    rd_begin(0, 1'b1, tbl1[0]);
    check("rd_start_clears_ready", 32'(buf_ready), 32'h0);
    for (int w = 1; w < 12; w++) rd_step(1'b1, tbl1[w]);
    rd_step(1'b1, 16'h3456);

    // Eight more samples without reading: sel 1 then 0, overflow on third completion
    for (int n = 0; n < 8; n++) begin
      send(24'h800000 + 24'(n) * 24'h010203, 24'h7F00FF - 24'(n) * 24'h000111);
      if (n == 3) begin
        check("h1_sel", 32'(buf_sel), 32'h1);
        check("h1_ready", 32'(buf_ready), 32'h1);
        check("h1_ovf_buf", 32'(ovf_buf), 32'h0);
      end
    end
    check("h2_sel", 32'(buf_sel), 32'h0);
    check("h2_ready", 32'(buf_ready), 32'h1);
    check("h2_ovf_buf", 32'(ovf_buf), 32'h1);
    rd_begin(0);
    for (int w = 0; w < 3; w++) rd_step();

    // Strobes every 2 cycles: the second and fourth are dropped
    for (int k = 0; k < 4; k++) begin
      in_i = 24'h0A0B0C + 24'(k);
      in_q = 24'hF1F2F3 - 24'(k);
      in_strobe = 1'b1;
      tick();
      in_strobe = 1'b0;
      tick();
      if (k == 0 || k == 2) model_write(24'h0A0B0C + 24'(k), 24'hF1F2F3 - 24'(k));
    end
    check("drop_wr_count", 32'(wr_count), 32'd2);
    check("drop_ovf_strobe", 32'(ovf_strobe), 32'h1);
    check("drop_sel_hold", 32'(buf_sel), 32'h0);
    send(24'h5A5A5A, 24'hA5A5A5);
    // rd_start on the completion edge reads the previous half (buf_sel=0)
    send(24'h3C3C3C, 24'hC3C3C3, 1'b1, 0);
    check("coll_ready", 32'(buf_ready), 32'h1);
    check("coll_sel", 32'(buf_sel), 32'h1);
    check("coll_cnt", 32'(wr_count), 32'h0);
    rd_step();
    rd_step();
    rd_begin(HALF);
    for (int w = 0; w < 5; w++) rd_step();

    // Drop enable during WR_Q of the third sample of a half
    send(24'h111111, 24'h222222);
    send(24'h333333, 24'h444444);
    in_i = 24'h555555;
    in_q = 24'h666666;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    m_half = 0;
    m_count = 0;
    tick();
    check("en_wr_count", 32'(wr_count), 32'h0);
    check("en_ovf_buf", 32'(ovf_buf), 32'h0);
    check("en_ovf_strobe", 32'(ovf_strobe), 32'h0);
    check("en_sel_kept", 32'(buf_sel), 32'h1);
    check("en_ready_kept", 32'(buf_ready), 32'h0);
    send(24'hC0FFEE, 24'h0BEEF0);
    send(24'h00ABCD, 24'hFF1234);
    send(24'h765432, 24'h89ABCD);
    send(24'hFEDCBA, 24'h012345);
    check("en_h0_sel", 32'(buf_sel), 32'h0);
    check("en_h0_ovf_buf", 32'(ovf_buf), 32'h0);
    rd_begin(0, 1'b1, 16'hFFEE);
    rd_step(1'b1, 16'hEEF0);
    rd_step(1'b1, 16'hC00B);

    // Async reset in the middle of a read
    for (int n = 0; n < 4; n++) send(24'h2468AC + 24'(n), 24'h13579B + 24'(n));
    check("pre_rst_ready", 32'(buf_ready), 32'h1);
    check("pre_rst_sel", 32'(buf_sel), 32'h1);
    rd_step();
    rd_next = 1'b1;
    if (m_rptr % HALF == HALF - 1) m_rptr = m_rptr - (HALF - 1);
    else                           m_rptr = m_rptr + 1;
    exp_q.push_back(m_mem[m_rptr]);
    tick();
    rd_next = 1'b0;
    #6;
    reset_n = 1'b0;
    #1;
    check("arst_rd_data", 32'(rd_data), 32'h0);
    check("arst_buf_ready", 32'(buf_ready), 32'h0);
    check("arst_buf_sel", 32'(buf_sel), 32'h0);
    check("arst_ovf_buf", 32'(ovf_buf), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
